// File: rtl/run_index_sequencer_pkg.sv
// Shared widths, encodings, code payload and the JPEG-LS J table for the run-mode sequencer.
package run_index_sequencer_pkg;

  localparam int unsigned J_LENGTH         = 4;
  localparam int unsigned RUNCOUNT_LENGTH  = 16;
  localparam int unsigned MODE_LENGTH      = 2;
  localparam int unsigned CODELEN_LENGTH   = 5;
  localparam int unsigned RUN_INDEX_LENGTH = 5;
  localparam int unsigned J_ENTRIES        = 32;

  localparam logic [RUN_INDEX_LENGTH-1:0] RUN_INDEX_MAX = 5'd31;

  typedef enum logic [MODE_LENGTH-1:0] {
    MODE_REG = 2'd0,
    MODE_RUN = 2'd1,
    MODE_INT = 2'd2,
    MODE_EOL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [RUNCOUNT_LENGTH-1:0] value;
    logic [CODELEN_LENGTH-1:0]  len;
  } code_t;

  localparam logic [J_LENGTH-1:0] J_TABLE [J_ENTRIES] = '{
    4'd0, 4'd0, 4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
    4'd2, 4'd2, 4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
    4'd4, 4'd4, 4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
    4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

endpackage

// File: rtl/run_index_sequencer_j_table.sv
// Combinational 32-entry ROM mapping RUNindex to J.
module run_index_sequencer_j_table
  import run_index_sequencer_pkg::*;
(
  input  logic [RUN_INDEX_LENGTH-1:0] run_index,
  output logic [J_LENGTH-1:0]         j_c
);

  always_comb begin
    j_c = J_TABLE[run_index];
  end

endmodule

// File: rtl/run_index_sequencer.sv
// JPEG-LS run-mode sequencer: tracks RUNindex/run count per token and issues
// run-segment, end-of-line and run-interruption codes over valid/ready.
module run_index_sequencer
  import run_index_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [MODE_LENGTH-1:0]      mode,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [RUNCOUNT_LENGTH-1:0]  code_value,
  output logic [CODELEN_LENGTH-1:0]   code_len,
  output logic [RUN_INDEX_LENGTH-1:0] run_index,
  output logic [J_LENGTH-1:0]         J,
  output logic [RUNCOUNT_LENGTH-1:0]  run_counter,
  output logic                        run_error
);

  state_e                      state_q, state_d;
  code_t                       code_d;
  logic                        code_valid_d;
  logic [RUNCOUNT_LENGTH-1:0]  counter_d;
  logic [RUN_INDEX_LENGTH-1:0] index_d;
  logic                        error_d;
  logic [J_LENGTH-1:0]         j_next_c;

  logic [RUNCOUNT_LENGTH-1:0]  cnt_inc;
  logic [RUNCOUNT_LENGTH-1:0]  seg_limit;
  logic                        seg_done;
  logic [RUN_INDEX_LENGTH-1:0] index_inc;
  logic [RUN_INDEX_LENGTH-1:0] index_dec;
  logic                        emit;

  // J is registered from the next index so it moves together with run_index
  run_index_sequencer_j_table u_j_table (
    .run_index (index_d),
    .j_c       (j_next_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      code_valid  <= 1'b0;
      pix_ready   <= 1'b1;
      code_value  <= '0;
      code_len    <= '0;
      run_index   <= '0;
      J           <= '0;
      run_counter <= '0;
      run_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_valid  <= code_valid_d;
      pix_ready   <= ~code_valid_d;
      code_value  <= code_d.value;
      code_len    <= code_d.len;
      run_index   <= index_d;
      J           <= j_next_c;
      run_counter <= counter_d;
      run_error   <= error_d;
    end
  end

  // Token acceptance, counter/index update and code generation
  always_comb begin
    state_d      = state_q;
    code_valid_d = code_valid;
    code_d       = '{value: code_value, len: code_len};
    counter_d    = run_counter;
    index_d      = run_index;
    error_d      = run_error;
    emit         = 1'b0;

    cnt_inc   = run_counter + RUNCOUNT_LENGTH'(1);
    seg_limit = RUNCOUNT_LENGTH'(1) << J;
    seg_done  = (cnt_inc == seg_limit);
    index_inc = (run_index == RUN_INDEX_MAX) ? run_index : run_index + RUN_INDEX_LENGTH'(1);
    index_dec = (run_index == '0) ? run_index : run_index - RUN_INDEX_LENGTH'(1);

    case (state_q)
      S_EMIT: begin
        if (code_ready) begin
          code_valid_d = 1'b0;
          state_d      = (run_counter == '0) ? S_IDLE : S_RUN;
        end
      end
      default: begin
        if (pix_valid) begin
          case (mode_e'(mode))
            MODE_RUN, MODE_EOL: begin
              if (seg_done) begin
                emit      = 1'b1;
                code_d    = '{value: RUNCOUNT_LENGTH'(1), len: CODELEN_LENGTH'(1)};
                counter_d = '0;
                index_d   = index_inc;
              end else if (mode_e'(mode) == MODE_EOL && cnt_inc != '0) begin
                emit      = 1'b1;
                code_d    = '{value: RUNCOUNT_LENGTH'(1), len: CODELEN_LENGTH'(1)};
                counter_d = '0;
              end else begin
                counter_d = cnt_inc;
              end
            end
            MODE_INT: begin
              // Leading 0 bit is implicit since run_counter < 2^J
              emit      = 1'b1;
              code_d    = '{value: run_counter,
                            len:   CODELEN_LENGTH'(J) + CODELEN_LENGTH'(1)};
              counter_d = '0;
              index_d   = index_dec;
            end
            MODE_REG: begin
              if (run_counter != '0) begin
                error_d = 1'b1;
              end
              counter_d = '0;
            end
            default: begin
              counter_d = run_counter;
            end
          endcase
          code_valid_d = emit;
          if (emit) begin
            state_d = S_EMIT;
          end else begin
            state_d = (counter_d == '0) ? S_IDLE : S_RUN;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_run_index_sequencer.sv
// Directed and randomized bench for run_index_sequencer against a JPEG-LS run-mode reference model.
module tb_run_index_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [1:0]  mode;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] code_value;
  logic [4:0]  code_len;
  logic [4:0]  run_index;
  logic [3:0]  J;
  logic [15:0] run_counter;
  logic        run_error;

  int checks = 0;
  int errors = 0;
  int dut_codes = 0;

  // Reference model state
  int m_ri;
  int m_cnt;
  int m_err;
  int jt [32] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3,
                  4, 4, 5, 5, 6, 6, 7, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  run_index_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .mode        (mode),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code_value  (code_value),
    .code_len    (code_len),
    .run_index   (run_index),
    .J           (J),
    .run_counter (run_counter),
    .run_error   (run_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_run_index"}, 32'(run_index), 32'(m_ri));
    chk({tag, "_J"}, 32'(J), 32'(jt[m_ri]));
    chk({tag, "_run_counter"}, 32'(run_counter), 32'(m_cnt));
    chk({tag, "_run_error"}, 32'(run_error), 32'(m_err));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pix_valid  = 1'b0;
    code_ready = 1'b0;
    mode       = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ri  = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  // stall < 0 leaves the code pending; full = 0 keeps bulk runs to the code_valid check
  task automatic send(input logic [1:0] m, input int stall, input bit full);
    int e, ev, el, c, seg;
    e = 0; ev = 0; el = 0;
    case (m)
      2'd1, 2'd3: begin
        c   = m_cnt + 1;
        seg = 1 << jt[m_ri];
        if (c == seg) begin
          e = 1; ev = 1; el = 1; m_cnt = 0;
          if (m_ri < 31) m_ri++;
        end else if (m == 2'd3) begin
          e = 1; ev = 1; el = 1; m_cnt = 0;
        end else begin
          m_cnt = c;
        end
      end
      2'd2: begin
        e = 1; ev = m_cnt; el = jt[m_ri] + 1; m_cnt = 0;
        if (m_ri > 0) m_ri--;
      end
      default: begin
        if (m_cnt != 0) m_err = 1;
        m_cnt = 0;
      end
    endcase

    @(negedge clk);
    if (full) chk("pix_ready_before", 32'(pix_ready), 1);
    pix_valid = 1'b1;
    mode      = m;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    if (code_valid === 1'b1) dut_codes++;
    chk("code_valid", 32'(code_valid), 32'(e));
    if (full) check_state("accept");
    if (e != 0) begin
      chk("code_value", 32'(code_value), 32'(ev));
      chk("code_len", 32'(code_len), 32'(el));
      if (stall >= 0) begin
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          pix_valid = 1'b1;
          mode      = 2'd2;
          @(posedge clk);
          #1;
          chk("stall_pix_ready", 32'(pix_ready), 0);
          chk("stall_code_valid", 32'(code_valid), 1);
          chk("stall_code_value", 32'(code_value), 32'(ev));
          chk("stall_code_len", 32'(code_len), 32'(el));
          chk("stall_run_index", 32'(run_index), 32'(m_ri));
        end
        @(negedge clk);
        pix_valid  = 1'b0;
        code_ready = 1'b1;
        @(posedge clk);
        #1;
        code_ready = 1'b0;
        chk("code_done", 32'(code_valid), 0);
      end
    end
  endtask

  initial begin
    logic [1:0] rm;
    int r;

    // Reset values
    do_reset();
    chk("rst_pix_ready", 32'(pix_ready), 1);
    chk("rst_code_valid", 32'(code_valid), 0);
    chk("rst_code_value", 32'(code_value), 0);
    chk("rst_code_len", 32'(code_len), 0);
    check_state("rst");

    // Four hits at J = 0 each close a segment
    for (int i = 0; i < 4; i++) send(2'd1, 0, 1);
    chk("t1_run_index", 32'(run_index), 4);
    chk("t1_J", 32'(J), 1);

    // Hit then interrupt at run_index 4: value 1, len 2, index 3
    send(2'd1, 0, 1);
    send(2'd2, 0, 1);
    chk("t2_run_index", 32'(run_index), 3);

    // EOL alone, then EOL completing a segment
    send(2'd1, 0, 1);
    send(2'd3, 0, 1);
    chk("t3_eol_index", 32'(run_index), 4);
    send(2'd1, 0, 1);
    send(2'd3, 0, 1);
    chk("t3_seg_index", 32'(run_index), 5);

    // Back-pressure on the packer for 5 cycles
    send(2'd1, 0, 1);
    send(2'd2, 5, 1);

    // Sticky run_error, then async reset in the middle of a pending code
    do_reset();
    for (int i = 0; i < 12; i++) send(2'd1, 0, 1);
    for (int i = 0; i < 3; i++) send(2'd1, 0, 1);
    send(2'd0, 0, 1);
    chk("t6_run_error", 32'(run_error), 1);
    send(2'd1, 0, 1);
    send(2'd3, 0, 1);
    send(2'd1, 0, 1);
    send(2'd2, -1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_code_valid", 32'(code_valid), 0);
    chk("async_run_counter", 32'(run_counter), 0);
    chk("async_pix_ready", 32'(pix_ready), 1);
    chk("async_run_error", 32'(run_error), 0);
    chk("async_run_index", 32'(run_index), 0);
    do_reset();

    // Randomized token stream with random packer stalls
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      rm = 2'd1;
      else if (r == 6) rm = 2'd3;
      else if (r <= 8) rm = 2'd2;
      else             rm = 2'd0;
      send(rm, int'($urandom_range(0, 3)), 1);
    end

    // Drive run_index to 31, then a full 2^15 segment yields exactly one code
    do_reset();
    while (m_ri < 31) send(2'd1, 0, 0);
    check_state("bulk_top");
    dut_codes = 0;
    for (int i = 0; i < 32768; i++) send(2'd1, 0, 0);
    chk("bulk_codes", 32'(dut_codes), 1);
    check_state("bulk_end");
    send(2'd2, 0, 1);

    // Interrupt at run_index 0 saturates
    do_reset();
    send(2'd2, 0, 1);
    chk("sat0_run_index", 32'(run_index), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
